// File: rtl/fx3_sf_pkg.sv
// Shared constants and types for the FX3 slave-FIFO loopback responder.
package fx3_sf_pkg;

  typedef enum logic [1:0] {
    FX3_ADDR_WR = 2'b00,
    FX3_ADDR_RD = 2'b11
  } fx3_sock_e;

  localparam int FX3_DW       = 32;
  localparam int FX3_FLAG_DLY = 3;

  typedef struct packed {
    logic a;
    logic b;
    logic c;
    logic d;
  } fx3_flags_t;

  localparam fx3_flags_t FX3_FLAGS_RST = '{a: 1'b1, b: 1'b1, c: 1'b0, d: 1'b0};

endpackage

// File: rtl/fx3_sf_ram.sv
// Simple dual-port loopback RAM: synchronous write, registered read (read pipeline stage 1).
module fx3_sf_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fx3_slave_fifo_model.sv
// FX3 slave-FIFO responder: loopback buffer, delayed flags A-D, pktend counter.
// Define FX3_MODEL_ERR_EN to implement sticky ovf/udf; otherwise both are tied low.
module fx3_slave_fifo_model
  import fx3_sf_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH),
  parameter int WM    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              slcs_n,
  input  logic              slwr_n,
  input  logic              slrd_n,
  input  logic              sloe_n,
  input  logic              pktend_n,
  input  logic [1:0]        faddr,
  inout  wire  [FX3_DW-1:0] fdata,
  output logic              flaga,
  output logic              flagb,
  output logic              flagc,
  output logic              flagd,
  output logic [AW:0]       level,
  output logic [15:0]       pkt_cnt,
  output logic              ovf,
  output logic              udf
);

  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_HI   = (AW+1)'(DEPTH - WM);
  localparam logic [AW:0] LVL_WM   = (AW+1)'(WM);
  localparam logic [AW:0] LVL_ONE  = (AW+1)'(1);

  logic              wr_sel, rd_sel;
  logic              push, pop, pkt_ev, wr_drop, rd_miss;
  logic [AW-1:0]     wr_ptr, rd_ptr, rd_addr_q;
  logic              rd_req_q, rd_vld_q;
  logic [FX3_DW-1:0] ram_q, dout_q;
  logic [AW:0]       level_q;
  fx3_flags_t        raw_flags;
  fx3_flags_t [FX3_FLAG_DLY-1:0] flag_pipe;

  always_comb begin
    wr_sel  = !slcs_n && (faddr == FX3_ADDR_WR);
    rd_sel  = !slcs_n && (faddr == FX3_ADDR_RD);
    push    = wr_sel && !slwr_n && (level_q != LVL_FULL);
    wr_drop = wr_sel && !slwr_n && (level_q == LVL_FULL);
    pop     = rd_sel && !slrd_n && (level_q != '0);
    rd_miss = rd_sel && !slrd_n && (level_q == '0);
    pkt_ev  = wr_sel && !pktend_n;
  end

  // A pop is first latched with its address, so the RAM read (stage 1) and the
  // output register (stage 2) land data on the bus two edges after the pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      rd_addr_q <= '0;
      rd_req_q  <= 1'b0;
      rd_vld_q  <= 1'b0;
      dout_q    <= '0;
      level_q   <= '0;
      pkt_cnt   <= '0;
    end else begin
      rd_req_q <= pop;
      rd_vld_q <= rd_req_q;
      if (push) begin
        wr_ptr  <= wr_ptr + AW'(1);
        level_q <= level_q + LVL_ONE;
      end
      if (pop) begin
        rd_addr_q <= rd_ptr;
        rd_ptr    <= rd_ptr + AW'(1);
        level_q   <= level_q - LVL_ONE;
      end
      if (rd_vld_q) begin
        dout_q <= ram_q;
      end
      if (pkt_ev) begin
        pkt_cnt <= pkt_cnt + 16'd1;
      end
    end
  end

  fx3_sf_ram #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (FX3_DW)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (fdata),
    .re    (rd_req_q),
    .raddr (rd_addr_q),
    .rdata (ram_q)
  );

  always_comb begin
    raw_flags   = FX3_FLAGS_RST;
    raw_flags.a = (level_q != LVL_FULL);
    raw_flags.b = !(level_q > LVL_HI);
    raw_flags.c = (level_q != '0);
    raw_flags.d = (level_q >= LVL_WM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_pipe <= {FX3_FLAG_DLY{FX3_FLAGS_RST}};
    end else begin
      flag_pipe <= {flag_pipe[FX3_FLAG_DLY-2:0], raw_flags};
    end
  end

  assign flaga = flag_pipe[FX3_FLAG_DLY-1].a;
  assign flagb = flag_pipe[FX3_FLAG_DLY-1].b;
  assign flagc = flag_pipe[FX3_FLAG_DLY-1].c;
  assign flagd = flag_pipe[FX3_FLAG_DLY-1].d;
  assign level = level_q;

`ifdef FX3_MODEL_ERR_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (wr_drop) ovf <= 1'b1;
      if (rd_miss) udf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
  assign udf = 1'b0;
  logic err_unused;
  assign err_unused = wr_drop ^ rd_miss;
`endif

  // Reset releases the bus as well, so nothing is driven while the read pipeline is cleared.
  assign fdata = (rst_n && rd_sel && !sloe_n) ? dout_q : 'z;

endmodule

// File: tb/tb_fx3_slave_fifo_model.sv
// Scoreboard bench for fx3_slave_fifo_model: queue-based reference model, delayed-level flag model.
`timescale 1ns/1ps
module tb_fx3_slave_fifo_model;

  localparam int DEPTH = 1024;
  localparam int WM    = 6;
  localparam int HMAX  = 16384;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        slcs_n = 1'b1, slwr_n = 1'b1, slrd_n = 1'b1, sloe_n = 1'b1, pktend_n = 1'b1;
  logic [1:0]  faddr = 2'b01;
  tri1  [31:0] fdata;
  logic        tb_oe = 1'b0;
  logic [31:0] tb_wdata = '0;
  logic        flaga, flagb, flagc, flagd, ovf, udf;
  logic [10:0] level;
  logic [15:0] pkt_cnt;

  // An undriven bus reads all ones through the tri1 net.
  assign fdata = tb_oe ? tb_wdata : 'z;

  always #5 clk = ~clk;

  fx3_slave_fifo_model #(.DEPTH(DEPTH), .WM(WM)) dut (
    .clk(clk), .rst_n(rst_n), .slcs_n(slcs_n), .slwr_n(slwr_n), .slrd_n(slrd_n),
    .sloe_n(sloe_n), .pktend_n(pktend_n), .faddr(faddr), .fdata(fdata),
    .flaga(flaga), .flagb(flagb), .flagc(flagc), .flagd(flagd),
    .level(level), .pkt_cnt(pkt_cnt), .ovf(ovf), .udf(udf)
  );

  typedef struct {
    int          due;
    logic [31:0] d;
  } sb_t;

  logic [31:0] mq[$];
  sb_t         sb[$];
  int          lvl_hist[HMAX];
  int          edge_n = 0;
  int          rst_edge = 0;
  int unsigned pkt_m = 0;
  bit          ovf_m = 0, udf_m = 0;
  logic [31:0] hold_d = '0;
  int          checks = 0, passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_n);
  endtask

  function automatic int lvl_at(input int k);
    if (k <= rst_edge) return 0;
    return lvl_hist[k];
  endfunction

  // flaga/flagc: not full / not empty; flagb: free >= WM; flagd: stored >= WM.
  function automatic logic [3:0] flags_of(input int l);
    return {l != DEPTH, (DEPTH - l) >= WM, l != 0, l >= WM};
  endfunction

  function automatic bit err_exp(input bit sticky);
`ifdef FX3_MODEL_ERR_EN
    return sticky;
`else
    return 1'b0 & sticky;
`endif
  endfunction

  task automatic cyc(input bit cs, input logic [1:0] a, input bit wr, input bit rd,
                     input bit oe, input bit pe, input logic [31:0] d);
    sb_t e;
    slcs_n = !cs; faddr = a; slwr_n = !wr; slrd_n = !rd; sloe_n = !oe; pktend_n = !pe;
    tb_oe = (a == 2'b00) && wr;
    tb_wdata = d;
    @(posedge clk);
    edge_n++;
    if (edge_n >= HMAX) begin
      $display("FAIL cycle_budget: got %0d expected < %0d", edge_n, HMAX);
      $fatal(1);
    end
    if (cs && a == 2'b00) begin
      if (wr) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else ovf_m = 1;
      end
      if (pe) pkt_m++;
    end
    if (cs && a == 2'b11 && rd) begin
      if (mq.size() > 0) begin
        e.due = edge_n + 2;
        e.d = mq.pop_front();
        sb.push_back(e);
      end else udf_m = 1;
    end
    lvl_hist[edge_n] = mq.size();
    #1;
  endtask

  task automatic wr_word(input logic [31:0] d); cyc(1, 2'b00, 1, 0, 0, 0, d); endtask
  task automatic rd_word();                     cyc(1, 2'b11, 0, 1, 1, 0, '0); endtask
  task automatic rd_idle();                     cyc(1, 2'b11, 0, 0, 1, 0, '0); endtask
  task automatic idle();                        cyc(0, 2'b00, 0, 0, 1, 0, '0); endtask

  task automatic drain();
    while (mq.size() > 0) rd_word();
    repeat (3) rd_idle();
  endtask

  task automatic do_reset(input int hold);
    rst_n = 1'b0;
    #1;
    chk("rst_level", level, 0);
    chk("rst_flags", {flaga, flagb, flagc, flagd}, 4'b1100);
    chk("rst_pkt", pkt_cnt, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_udf", udf, 0);
    chk("rst_bus", fdata, 32'hFFFF_FFFF);
    mq.delete(); sb.delete();
    hold_d = '0; ovf_m = 0; udf_m = 0; pkt_m = 0;
    repeat (hold) @(posedge clk);
    #1;
    rst_n = 1'b1;
    rst_edge = edge_n;
  endtask

  always @(negedge clk) begin
    bit due_now;
    bit driven;
    if (rst_n) begin
      chk("level", level, lvl_at(edge_n));
      chk("flags", {flaga, flagb, flagc, flagd}, flags_of(lvl_at(edge_n - 3)));
      chk("pkt_cnt", pkt_cnt, pkt_m[15:0]);
      chk("ovf", ovf, err_exp(ovf_m));
      chk("udf", udf, err_exp(udf_m));
      due_now = 0;
      if (sb.size() > 0 && sb[0].due == edge_n) begin
        hold_d = sb[0].d;
        due_now = 1;
        void'(sb.pop_front());
      end
      driven = !slcs_n && !sloe_n && faddr == 2'b11;
      if (driven) chk(due_now ? "rdata" : "rhold", fdata, hold_d);
      else if (!tb_oe) chk("bus_release", fdata, 32'hFFFF_FFFF);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [1:0] a;
    #2;
    do_reset(3);
    repeat (10) idle();

    for (int i = 1; i <= 16; i++) wr_word(32'(i));
    repeat (16) rd_word();
    repeat (6) rd_idle();

    repeat (400) begin
      a = 2'($urandom_range(0, 3));
      cyc($urandom_range(0, 7) != 0, a, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
          $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0, $urandom & 32'h7FFF_FFFF);
    end
    drain();

    for (int i = 0; i < DEPTH; i++) wr_word($urandom & 32'h7FFF_FFFF);
    wr_word(32'hDEAD_BEEF);
    repeat (4) idle();
    chk("full_level", level, DEPTH);
    chk("full_flaga", flaga, 0);
    chk("full_ovf", ovf, err_exp(1'b1));
    repeat (600) rd_word();
    repeat (3) rd_idle();
    for (int i = 0; i < 600; i++) wr_word($urandom & 32'h7FFF_FFFF);
    drain();

    rd_word();
    repeat (3) rd_idle();
    chk("empty_udf", udf, err_exp(1'b1));

    for (int i = 0; i < 10; i++) wr_word(32'h1000 + 32'(i));
    repeat (5) rd_word();
    do_reset(2);
    repeat (4) rd_idle();

    cyc(1, 2'b00, 0, 0, 0, 1, '0);
    idle();
    cyc(1, 2'b00, 1, 0, 0, 1, 32'hA5A5_A5A5);
    idle();
    cyc(1, 2'b00, 0, 0, 0, 1, '0);
    cyc(1, 2'b11, 0, 0, 0, 1, '0);
    repeat (4) idle();
    chk("pkt_cnt_3", pkt_cnt, 3);
    chk("pkt_level_1", level, 1);
    drain();
    repeat (4) idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/fx3_slave_fifo_model.md
# fx3_slave_fifo_model

Synthesizable responder for the FX3 Slave FIFO synchronous interface. It plays the FX3 side of the link that `usb_controller` drives as master: it accepts slave-FIFO writes, returns them on slave-FIFO reads through one loopback buffer, and generates flags A–D with FX3-like latency. It sits in the loopback test build in place of the real FX3 pins, clocked by the same 100 MHz domain as the master.

## Interface
Parameters:
- `DEPTH`, 1024: loopback buffer depth in 32-bit words; must be a power of 2.
- `AW`, $clog2(DEPTH): pointer width (derived; do not override).
- `WM`, 6: watermark in words for the partial flags B and D.

Ports:
- `clk`  in  1  interface clock; the master's PCLK domain.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `slcs_n`  in  1  chip select, active low.
- `slwr_n`  in  1  write strobe, active low.
- `slrd_n`  in  1  read strobe, active low.
- `sloe_n`  in  1  output enable, active low.
- `pktend_n`  in  1  packet end, active low.
- `faddr`  in  2  socket address: 2'b00 selects the write socket, 2'b11 selects the read socket.
- `fdata`  inout  32  data bus.
- `flaga`  out  1  write socket not full; low means full.
- `flagb`  out  1  write socket not partially full; low when free words < WM.
- `flagc`  out  1  read socket not empty; low means empty.
- `flagd`  out  1  read socket not partially empty; low when stored words < WM.
- `level`  out  AW+1  current buffer occupancy in words.
- `pkt_cnt`  out  16  count of committed pktend events; wraps at 16'hFFFF to 0.
- `ovf`  out  1  sticky overflow error.
- `udf`  out  1  sticky underflow error.

## Operation
- Transfers are qualified only when `slcs_n`=0. Addresses 2'b01 and 2'b10 are ignored.
- **Write:** `slcs_n`=0, `faddr`=00, `slwr_n`=0 at a rising edge.
  - If the buffer is not full, `fdata` is pushed.
  - If the buffer is full, the word is dropped, `ovf` is set and `level` is unchanged.
- **Packet end:** `pktend_n`=0 with `faddr`=00 increments `pkt_cnt`. This applies whether or not `slwr_n` is low in the same cycle; a same-cycle write is still pushed.
- **Read:** `slcs_n`=0, `faddr`=11, `slrd_n`=0 at a rising edge.
  - If the buffer is not empty, one word is popped.
  - If the buffer is empty, nothing is popped, `udf` is set, and the output register holds its previous value.
- **Bus drive:** the model drives `fdata` only when `slcs_n`=0, `sloe_n`=0 and `faddr`=11; otherwise `fdata` is 'z'. Any other condition releases the bus within the same cycle, combinationally.
- **Occupancy:** `level` is updated by push/pop at each edge. Push and pop cannot occur in the same cycle because `faddr` is exclusive.
- **Pointers:** AW bits each, wrapping modulo DEPTH. Full/empty are decided from `level` (=DEPTH / =0), not from pointer equality.
- **Flag computation:** raw flags are computed from the post-update `level`, then pass through a FLAG_DLY-stage register pipeline before reaching the ports.
- **Reset values:** `flaga`=1, `flagb`=1, `flagc`=0, `flagd`=0, `level`=0, `pkt_cnt`=0, `ovf`=0, `udf`=0, `fdata`='z'. All flag pipeline stages reset to these same values.
- **Reset mid-operation:** pointers, read pipeline and flags are cleared asynchronously, and buffered data is discarded.

## Timing
- **Write latency:** a word pushed at edge N is readable by a pop at edge N+1 or later.
- **Read latency:** a pop at edge N presents its data on `fdata` after edge N+2, via two pipeline registers. Back-to-back pops produce back-to-back data.
- **Flag latency:** FLAG_DLY = 3 edges. An event at edge N changes the flag output after edge N+3. The master must honour the watermarks (WM ≥ FLAG_DLY+pipeline slack); writing past the end still obeys the overflow rule.
- **Flag boundaries:**
  - `flagb` falls when free words < WM, i.e. `level` > DEPTH−WM.
  - `flagd` falls when `level` < WM.
  - With DEPTH=1024 and WM=6: `flagb` falls at `level` 1019; `flagd` is low for `level` 0–5.

## Configuration
- `FX3_MODEL_ERR_EN` defined: `ovf` and `udf` are implemented as sticky registers, cleared only by reset.
- `FX3_MODEL_ERR_EN` undefined: `ovf` and `udf` are tied to 0.
- Overflow drop and underflow hold behaviour are identical in both builds.

## Structure
- **Package `fx3_sf_pkg`** holds:
  - `FX3_ADDR_WR`=2'b00 and `FX3_ADDR_RD`=2'b11
  - `FX3_DW`=32
  - `FX3_FLAG_DLY`=3
- **Sub-module `fx3_sf_ram`:** simple dual-port RAM, DEPTH×32, with synchronous write and registered read. The registered read forms pipeline stage 1 of the read path; stage 2 is the output register in the top level.

## Test plan
- Reset, then idle: all outputs equal their reset values, `fdata`='z', and the flags are stable for 10 cycles.
- Write 16 words 0x0000_0001..0x0000_0010 at `faddr`=00, then 16 back-to-back reads at `faddr`=11 with `sloe_n`=0:
  - `fdata` shows 1..16 starting 2 cycles after the first `slrd_n` edge;
  - `flagc` is high 3 cycles after the first push and low 3 cycles after the last pop.
- Fill to DEPTH=1024, then write 0xDEAD_BEEF:
  - `flaga` is low 3 cycles after the 1024th push and `level`=1024;
  - the extra word is dropped and `ovf`=1 (0 without the macro);
  - the subsequent read-back returns the original 1024 words in order, including across pointer wrap after a partial drain and refill of 600 words.
- Read when empty: `udf`=1, `level` stays 0, and `fdata` holds the last valid word.
- Three pktend pulses at `faddr`=00, one of them with `slwr_n`=0 (data 0xA5A5_A5A5): `pkt_cnt`=3 and `level`=1; a pktend pulse at `faddr`=11 leaves `pkt_cnt` unchanged.
- Assert `rst_n`=0 mid-burst, after 5 of 10 reads: `fdata`='z', `level`=0 and `flagc`=0 immediately, and no stale data appears after release.
